// File: rtl/user_locked_regfile_if.sv
// Request/response bundle for user_locked_regfile: one requester ID shared by
// write, lock/unlock and read strobes, plus registered read and violation outputs.
interface user_locked_regfile_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ID_W     = 2,
  parameter int CNT_W    = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic [ID_W-1:0]   usr_id;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              lock_req;
  logic              unlock_req;
  logic [AW-1:0]     lock_addr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_locked;
  logic [ID_W-1:0]   rd_owner;
  logic              viol;
  logic [CNT_W-1:0]  viol_cnt;

  modport master (
    output usr_id, wr_en, wr_addr, wr_data, lock_req, unlock_req, lock_addr, rd_addr,
    input  rd_data, rd_locked, rd_owner, viol, viol_cnt
  );

  modport slave (
    input  usr_id, wr_en, wr_addr, wr_data, lock_req, unlock_req, lock_addr, rd_addr,
    output rd_data, rd_locked, rd_owner, viol, viol_cnt
  );
endinterface

// File: rtl/user_locked_regfile.sv
// Bank of owner-lockable registers: writes gated by requester ID, denied
// requests flagged for one cycle and counted in a saturating counter.
module user_locked_regfile #(
  parameter int              DATA_W   = 8,
  parameter int              NUM_REGS = 4,
  parameter int              ID_W     = 2,
  parameter logic [ID_W-1:0] ADMIN_ID = ID_W'(2),
  parameter int              CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  user_locked_regfile_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] value_reg  [NUM_REGS];
  logic [DATA_W-1:0] value_next [NUM_REGS];
  logic [ID_W-1:0]   owner_reg  [NUM_REGS];
  logic [ID_W-1:0]   owner_next [NUM_REGS];
  logic              locked_reg [NUM_REGS];
  logic              locked_next[NUM_REGS];

  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_locked_reg;
  logic [ID_W-1:0]   rd_owner_reg;
  logic              viol_reg;
  logic [CNT_W-1:0]  viol_cnt_reg;

  // All permission decisions use the pre-edge state of the addressed entry.
  logic wr_ok, wr_denied;
  logic lock_only, unlock_only, both_req;
  logic lock_ok, lock_denied, unlock_ok, unlock_denied;
  logic any_denied;

  assign wr_ok = locked_reg[bus.wr_addr] ? (bus.usr_id == owner_reg[bus.wr_addr])
                                         : (bus.usr_id == ADMIN_ID);
  assign wr_denied = bus.wr_en && !wr_ok;

  assign both_req    = bus.lock_req && bus.unlock_req;
  assign lock_only   = bus.lock_req && !bus.unlock_req;
  assign unlock_only = bus.unlock_req && !bus.lock_req;

  assign lock_ok     = lock_only && !locked_reg[bus.lock_addr];
  assign lock_denied = lock_only && locked_reg[bus.lock_addr];
  assign unlock_ok   = unlock_only && locked_reg[bus.lock_addr] &&
                       (bus.usr_id == owner_reg[bus.lock_addr] || bus.usr_id == ADMIN_ID);
  assign unlock_denied = unlock_only && !unlock_ok;

  assign any_denied = wr_denied || lock_denied || unlock_denied || both_req;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      logic wr_hit, lk_hit;
      assign wr_hit = bus.wr_en && wr_ok && (bus.wr_addr == AW'(gi));
      assign lk_hit = (bus.lock_addr == AW'(gi));

      always_comb begin
        value_next[gi]  = value_reg[gi];
        owner_next[gi]  = owner_reg[gi];
        locked_next[gi] = locked_reg[gi];
        if (wr_hit) value_next[gi] = bus.wr_data;
        if (lock_ok && lk_hit) begin
          locked_next[gi] = 1'b1;
          owner_next[gi]  = bus.usr_id;
        end else if (unlock_ok && lk_hit) begin
          locked_next[gi] = 1'b0;
          owner_next[gi]  = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_reg[gi]  <= '0;
          owner_reg[gi]  <= '0;
          locked_reg[gi] <= 1'b0;
        end else begin
          value_reg[gi]  <= value_next[gi];
          owner_reg[gi]  <= owner_next[gi];
          locked_reg[gi] <= locked_next[gi];
        end
      end
    end
  endgenerate

  // Read port returns post-update state so same-edge writes/locks are seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg   <= '0;
      rd_locked_reg <= 1'b0;
      rd_owner_reg  <= '0;
      viol_reg      <= 1'b0;
      viol_cnt_reg  <= '0;
    end else begin
      rd_data_reg   <= value_next[bus.rd_addr];
      rd_locked_reg <= locked_next[bus.rd_addr];
      rd_owner_reg  <= owner_next[bus.rd_addr];
      viol_reg      <= any_denied;
      if (any_denied && viol_cnt_reg != {CNT_W{1'b1}})
        viol_cnt_reg <= viol_cnt_reg + 1'b1;
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_locked = rd_locked_reg;
  assign bus.rd_owner  = rd_owner_reg;
  assign bus.viol      = viol_reg;
  assign bus.viol_cnt  = viol_cnt_reg;
endmodule

// File: tb/tb_user_locked_regfile.sv
// Directed test of user_locked_regfile: ownership rules, violation counting,
// saturation and asynchronous reset.
module tb_user_locked_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  user_locked_regfile_if #(.DATA_W(8), .NUM_REGS(4), .ID_W(2), .CNT_W(8)) bus ();

  user_locked_regfile #(
    .DATA_W(8), .NUM_REGS(4), .ID_W(2), .ADMIN_ID(2'h2), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; strobes return to idle afterwards.
  task automatic req(input logic [1:0] id, input logic we, input logic [1:0] wa,
                     input logic [7:0] wd, input logic lk, input logic ul,
                     input logic [1:0] la, input logic [1:0] ra);
    bus.usr_id = id; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.lock_req = lk; bus.unlock_req = ul; bus.lock_addr = la; bus.rd_addr = ra;
    tick();
    bus.wr_en = 1'b0; bus.lock_req = 1'b0; bus.unlock_req = 1'b0;
    $display("t=%0t id=%0d we=%0b wa=%0d wd=%02h lk=%0b ul=%0b la=%0d ra=%0d -> rd=%02h lck=%0b own=%0d viol=%0b cnt=%0d",
             $time, id, we, wa, wd, lk, ul, la, ra, bus.rd_data, bus.rd_locked,
             bus.rd_owner, bus.viol, bus.viol_cnt);
  endtask

  initial begin
    bus.usr_id = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.lock_req = 1'b0; bus.unlock_req = 1'b0; bus.lock_addr = '0; bus.rd_addr = '0;
    rst_n = 1'b0;
    tick(); tick();
    check_val("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check_val("rst_rd_locked", 32'(bus.rd_locked), 32'h0);
    check_val("rst_rd_owner", 32'(bus.rd_owner), 32'h0);
    check_val("rst_viol", 32'(bus.viol), 32'h0);
    check_val("rst_viol_cnt", 32'(bus.viol_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Admin write to a free entry
    req(2'd2, 1'b1, 2'd1, 8'hA5, 1'b0, 1'b0, 2'd0, 2'd1);
    check_val("admin_wr_data", 32'(bus.rd_data), 32'hA5);
    check_val("admin_wr_locked", 32'(bus.rd_locked), 32'h0);
    check_val("admin_wr_viol", 32'(bus.viol), 32'h0);
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1);
    check_val("admin_wr_hold", 32'(bus.rd_data), 32'hA5);
    check_val("admin_wr_viol2", 32'(bus.viol), 32'h0);

    // User 1 owns entry 0; user 2 write denied, owner write accepted
    req(2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0);
    check_val("lock0_locked", 32'(bus.rd_locked), 32'h1);
    check_val("lock0_owner", 32'(bus.rd_owner), 32'h1);
    check_val("lock0_viol", 32'(bus.viol), 32'h0);
    req(2'd2, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 2'd0, 2'd0);
    check_val("deny_wr_data", 32'(bus.rd_data), 32'h0);
    check_val("deny_wr_viol", 32'(bus.viol), 32'h1);
    check_val("deny_wr_cnt", 32'(bus.viol_cnt), 32'h1);
    req(2'd1, 1'b1, 2'd0, 8'h3C, 1'b0, 1'b0, 2'd0, 2'd0);
    check_val("owner_wr_data", 32'(bus.rd_data), 32'h3C);
    check_val("owner_wr_viol", 32'(bus.viol), 32'h0);
    check_val("owner_wr_cnt", 32'(bus.viol_cnt), 32'h1);

    // Entry 2: foreign unlock denied, admin unlock allowed, value kept
    req(2'd1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 2'd2);
    req(2'd1, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b0, 2'd0, 2'd2);
    check_val("e2_owner_wr", 32'(bus.rd_data), 32'h5A);
    req(2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd2);
    check_val("e2_bad_unlock_viol", 32'(bus.viol), 32'h1);
    check_val("e2_bad_unlock_cnt", 32'(bus.viol_cnt), 32'h2);
    check_val("e2_bad_unlock_lck", 32'(bus.rd_locked), 32'h1);
    req(2'd2, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd2, 2'd2);
    check_val("e2_admin_unlock_lck", 32'(bus.rd_locked), 32'h0);
    check_val("e2_admin_unlock_own", 32'(bus.rd_owner), 32'h0);
    check_val("e2_admin_unlock_val", 32'(bus.rd_data), 32'h5A);
    check_val("e2_admin_unlock_viol", 32'(bus.viol), 32'h0);

    // Same cycle lock + write on free entry 3 by user 0
    req(2'd0, 1'b1, 2'd3, 8'hFF, 1'b1, 1'b0, 2'd3, 2'd3);
    check_val("lkwr_locked", 32'(bus.rd_locked), 32'h1);
    check_val("lkwr_owner", 32'(bus.rd_owner), 32'h0);
    check_val("lkwr_data", 32'(bus.rd_data), 32'h0);
    check_val("lkwr_cnt", 32'(bus.viol_cnt), 32'h3);

    // Re-lock by owner, lock+unlock together, admin write to a foreign lock
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd3, 2'd3);
    check_val("relock_cnt", 32'(bus.viol_cnt), 32'h4);
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd3, 2'd3);
    check_val("both_cnt", 32'(bus.viol_cnt), 32'h5);
    check_val("both_locked", 32'(bus.rd_locked), 32'h1);
    req(2'd2, 1'b1, 2'd0, 8'h99, 1'b0, 1'b0, 2'd0, 2'd0);
    check_val("admin_foreign_cnt", 32'(bus.viol_cnt), 32'h6);
    check_val("admin_foreign_data", 32'(bus.rd_data), 32'h3C);
    // Two denials in one cycle count once
    req(2'd3, 1'b1, 2'd0, 8'h77, 1'b1, 1'b0, 2'd0, 2'd0);
    check_val("dual_deny_cnt", 32'(bus.viol_cnt), 32'h7);
    check_val("dual_deny_owner", 32'(bus.rd_owner), 32'h1);
    req(2'd1, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0, 2'd0, 2'd1);
    check_val("nonadmin_free_cnt", 32'(bus.viol_cnt), 32'h8);
    check_val("nonadmin_free_data", 32'(bus.rd_data), 32'hA5);
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    check_val("idle_viol", 32'(bus.viol), 32'h0);

    // Saturation: 300 denied cycles
    for (int i = 0; i < 300; i++) begin
      bus.usr_id = 2'd3; bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 8'hEE;
      tick();
    end
    bus.wr_en = 1'b0;
    check_val("sat_cnt", 32'(bus.viol_cnt), 32'hFF);
    check_val("sat_viol", 32'(bus.viol), 32'h1);
    req(2'd3, 1'b1, 2'd0, 8'hEE, 1'b0, 1'b0, 2'd0, 2'd0);
    check_val("sat_hold", 32'(bus.viol_cnt), 32'hFF);
    check_val("sat_data", 32'(bus.rd_data), 32'h3C);

    // Asynchronous reset mid-cycle
    bus.rd_addr = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_rd_data", 32'(bus.rd_data), 32'h0);
    check_val("arst_rd_locked", 32'(bus.rd_locked), 32'h0);
    check_val("arst_rd_owner", 32'(bus.rd_owner), 32'h0);
    check_val("arst_viol", 32'(bus.viol), 32'h0);
    check_val("arst_viol_cnt", 32'(bus.viol_cnt), 32'h0);
    #2 rst_n = 1'b1;
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd3);
    check_val("post_rst_e3_locked", 32'(bus.rd_locked), 32'h0);
    req(2'd0, 1'b1, 2'd3, 8'h44, 1'b0, 1'b0, 2'd0, 2'd3);
    check_val("post_rst_e3_wr_viol", 32'(bus.viol), 32'h1);
    check_val("post_rst_e3_data", 32'(bus.rd_data), 32'h0);
    req(2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1);
    check_val("post_rst_e1_data", 32'(bus.rd_data), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/user_locked_regfile.md
# user_locked_regfile

Parametrised bank of user-owned registers for the access-control subsystem. Generalises the single user-locked register to NUM_REGS entries. Each entry carries a runtime-programmable owner lock, writes are gated by the requesting user ID, and every denied access is flagged and counted. Sits between the shared configuration bus and the security-sensitive configuration consumers.

## Interface
- DATA_W, 8: register width.
- NUM_REGS, 4: number of entries; power of two, at least 2. AW = $clog2(NUM_REGS).
- ID_W, 2: user ID width.
- ADMIN_ID, 2'h2: privileged user ID, ID_W wide.
- CNT_W, 8: violation counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- usr_id  in  ID_W  ID of the requester this cycle; applies to all requests.
- wr_en  in  1  write request.
- wr_addr  in  AW  write target entry.
- wr_data  in  DATA_W  write data.
- lock_req  in  1  claim ownership of entry lock_addr for usr_id.
- unlock_req  in  1  release ownership of entry lock_addr.
- lock_addr  in  AW  lock/unlock target entry.
- rd_addr  in  AW  read address.
- rd_data  out  DATA_W  registered read data.
- rd_locked  out  1  registered lock state of entry rd_addr.
- rd_owner  out  ID_W  registered owner of entry rd_addr; 0 when the entry is free.
- viol  out  1  one-cycle pulse: at least one request was denied in the previous cycle.
- viol_cnt  out  CNT_W  saturating count of denied cycles.

## Operation
- Per-entry state is FREE or LOCKED, plus owner[ID_W] and value[DATA_W].
- Write permission, evaluated against the entry state before the edge:
  - FREE: allowed only when usr_id == ADMIN_ID.
  - LOCKED: allowed only when usr_id == owner.
  - ADMIN does not override another user's lock.
- Permitted write: value <= wr_data. Denied write: value is unchanged and the write counts as a violation.
- lock_req on a FREE entry: state becomes LOCKED and owner <= usr_id; any ID may claim.
- lock_req on a LOCKED entry: denied, including a re-lock by the current owner.
- unlock_req: allowed when LOCKED and usr_id is the owner or ADMIN_ID. The entry returns to FREE, owner <= 0, and value is kept. Otherwise denied.
- lock_req and unlock_req asserted together: both are ignored, and the cycle is one violation.
- Write and lock/unlock in the same cycle, even to the same entry:
  - The write is checked against the pre-edge state.
  - Example: free entry, a non-admin user sends lock_req and wr_en together. The lock is granted and the write is denied.
- Violation accounting:
  - Any number of denials in one cycle sets viol for one cycle.
  - viol_cnt increments by exactly 1 per such cycle.
  - viol_cnt saturates at all-ones and never wraps.
- Reads have no access control and are never violations.

## Timing
- Reset, asynchronous: all values 0, all entries FREE, all owners 0. rd_data = 0, rd_locked = 0, rd_owner = 0, viol = 0, viol_cnt = 0.
- Reset mid-operation clears everything immediately, including locks, so no lock survives reset.
- Write, lock and unlock take effect at the edge on which they are sampled.
- Read latency is 1 cycle. rd_data/rd_locked/rd_owner at edge N+1 reflect rd_addr at edge N and the state after edge N's updates. A same-address write or lock at edge N is visible one cycle later.
- viol and viol_cnt update at the same edge as the denied request, so they are visible in the following cycle.
- No handshake: every request is a single-cycle strobe, and the block never stalls.

## Test plan
- Reset, then ADMIN (id 2) writes 0xA5 to entry 1 -> one cycle after the write, reading entry 1 gives rd_data = 0xA5, rd_locked = 0, viol never asserts.
- User 1 locks entry 0. User 2 writes 0x11 to entry 0 -> denied: value stays 0, viol pulses once, viol_cnt = 1. User 1 then writes 0x3C -> accepted, rd_data = 0x3C.
- User 1 locks entry 2. User 3 unlocks entry 2 -> denied, viol_cnt + 1. ADMIN unlocks entry 2 -> allowed: rd_locked = 0, rd_owner = 0, value kept.
- Same cycle: free entry 3, user 0 asserts lock_req and wr_en with 0xFF -> lock granted, owner = 0, write denied, viol_cnt increments by exactly 1.
- Force 300 denied cycles with CNT_W = 8 -> viol_cnt saturates at 0xFF and stays there. Assert rst_n low mid-cycle -> all outputs 0 and all entries FREE immediately, without waiting for a clock edge.
